// File: rtl/dram_port_ctrl_pkg.sv
// Shared encodings for dram_port_ctrl: access-size codes carried on w_dram_ctrl,
// FSM state encoding and small size-decode helpers.
package dram_port_ctrl_pkg;

   localparam logic [1:0] SZ_BYTE       = 2'd0;
   localparam logic [1:0] SZ_HALF       = 2'd1;
   localparam logic [1:0] SZ_WORD       = 2'd2;
   localparam int         CTRL_ZEXT_BIT = 2;

   typedef enum logic [1:0] {
      DPC_IDLE  = 2'd0,
      DPC_BEAT0 = 2'd1,
      DPC_BEAT1 = 2'd2,
      DPC_DONE  = 2'd3
   } dpc_state_t;

   // Size code 3 is treated as a word access.
   function automatic logic [3:0] size_mask(input logic [1:0] size);
      case (size)
         SZ_BYTE: size_mask = 4'b0001;
         SZ_HALF: size_mask = 4'b0011;
         default: size_mask = 4'b1111;
      endcase
   endfunction

   function automatic logic [2:0] size_nbytes(input logic [1:0] size);
      case (size)
         SZ_BYTE: size_nbytes = 3'd1;
         SZ_HALF: size_nbytes = 3'd2;
         default: size_nbytes = 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/dram_port_ctrl_if.sv
// Core-strobe and memory-beat signals of dram_port_ctrl; slave is the controller's view,
// master is the view of whatever drives the strobes and answers the beats.
interface dram_port_ctrl_if;

   logic [31:0] w_dram_addr;
   logic [31:0] w_dram_wdata;
   logic        w_dram_le;
   logic        w_dram_we;
   logic [2:0]  w_dram_ctrl;
   logic [31:0] w_dram_odata;
   logic        w_dram_busy;
   logic        o_mem_req;
   logic        o_mem_we;
   logic [31:0] o_mem_addr;
   logic [31:0] o_mem_wdata;
   logic [3:0]  o_mem_wstrb;
   logic        i_mem_ack;
   logic [31:0] i_mem_rdata;
   logic        o_err;

   modport slave (
      input  w_dram_addr, w_dram_wdata, w_dram_le, w_dram_we, w_dram_ctrl,
      input  i_mem_ack, i_mem_rdata,
      output w_dram_odata, w_dram_busy,
      output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb, o_err
   );

   modport master (
      output w_dram_addr, w_dram_wdata, w_dram_le, w_dram_we, w_dram_ctrl,
      output i_mem_ack, i_mem_rdata,
      input  w_dram_odata, w_dram_busy,
      input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb, o_err
   );

endinterface

// File: rtl/dram_port_ctrl_lane_align.sv
// dram_lane_align: combinational lane steering for one access -- split detection, per-beat
// byte strobes and write data, and extraction/extension of load data from two read beats.
module dram_lane_align
   import dram_port_ctrl_pkg::*;
(
   input  logic [1:0]  i_off,
   input  logic [1:0]  i_size,
   input  logic        i_zext,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rdata0,
   input  logic [31:0] i_rdata1,
   output logic        o_split,
   output logic [3:0]  o_wstrb0,
   output logic [3:0]  o_wstrb1,
   output logic [31:0] o_wdata0,
   output logic [31:0] o_wdata1,
   output logic [31:0] o_ldata
);

   logic [5:0]  w_bit_off;
   logic [2:0]  w_end;
   logic [7:0]  w_mask_sh;
   logic [63:0] w_wdata_sh;
   logic [31:0] w_rdata_sh;

   assign w_bit_off = {i_off, 3'b000};
   assign w_end     = {1'b0, i_off} + size_nbytes(i_size);
   assign o_split   = (w_end > 3'd4);

   // Shifting into a double-width field yields beat 0 in the low half and beat 1 in the high half.
   assign w_mask_sh  = {4'b0000, size_mask(i_size)} << i_off;
   assign w_wdata_sh = {32'd0, i_wdata} << w_bit_off;
   assign w_rdata_sh = 32'({i_rdata1, i_rdata0} >> w_bit_off);

   assign o_wstrb0 = w_mask_sh[3:0];
   assign o_wstrb1 = w_mask_sh[7:4];
   assign o_wdata0 = w_wdata_sh[31:0];
   assign o_wdata1 = w_wdata_sh[63:32];

   // Truncate the realigned read data to the access size and extend it.
   always_comb begin
      o_ldata = w_rdata_sh;
      case (i_size)
         SZ_BYTE: o_ldata = {{24{~i_zext & w_rdata_sh[7]}}, w_rdata_sh[7:0]};
         SZ_HALF: o_ldata = {{16{~i_zext & w_rdata_sh[15]}}, w_rdata_sh[15:0]};
         default: o_ldata = w_rdata_sh;
      endcase
   end

endmodule

// File: rtl/dram_port_ctrl.sv
// dram_port_ctrl: turns a one-cycle DRAM load/store strobe into word-aligned req/ack beats,
// splitting boundary-crossing accesses in two. Optional per-beat timeout: define DRAM_TIMEOUT_EN.
module dram_port_ctrl
   import dram_port_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter logic [31:0] ERR_RDATA      = 32'hFFFF_FFFF
) (
   input  logic            clk,
   input  logic            rst,
   dram_port_ctrl_if.slave bus
);

   dpc_state_t  r_state, w_state_nxt;
   logic [1:0]  r_off, w_off_nxt;
   logic [1:0]  r_size, w_size_nxt;
   logic        r_zext, w_zext_nxt;
   logic        r_store, w_store_nxt;
   logic [31:0] r_wdata, w_wdata_nxt;
   logic [31:0] r_rdata0, w_rdata0_nxt;
   logic        r_req, w_req_nxt;
   logic        r_mem_we, w_mem_we_nxt;
   logic [31:0] r_mem_addr, w_mem_addr_nxt;
   logic [31:0] r_mem_wdata, w_mem_wdata_nxt;
   logic [3:0]  r_mem_wstrb, w_mem_wstrb_nxt;
   logic        r_busy, w_busy_nxt;
   logic [31:0] r_odata, w_odata_nxt;

   logic        w_live, w_in_beat, w_last_ack, w_tmo, w_end_txn, w_split;
   logic [1:0]  w_al_off, w_al_size;
   logic [31:0] w_al_wdata, w_al_rd0, w_al_rd1, w_ldata, w_wdata0, w_wdata1;
   logic [3:0]  w_wstrb0, w_wstrb1;

   // In IDLE the aligner sees the incoming strobe so beat 0 can be registered immediately.
   assign w_live     = (r_state == DPC_IDLE);
   assign w_in_beat  = (r_state == DPC_BEAT0) || (r_state == DPC_BEAT1);
   assign w_al_off   = w_live ? bus.w_dram_addr[1:0] : r_off;
   assign w_al_size  = w_live ? bus.w_dram_ctrl[1:0] : r_size;
   assign w_al_wdata = w_live ? bus.w_dram_wdata : r_wdata;
   assign w_al_rd0   = (r_state == DPC_BEAT1) ? r_rdata0 : bus.i_mem_rdata;
   assign w_al_rd1   = (r_state == DPC_BEAT1) ? bus.i_mem_rdata : 32'd0;

   dram_lane_align u_align (
      .i_off    (w_al_off),
      .i_size   (w_al_size),
      .i_zext   (r_zext),
      .i_wdata  (w_al_wdata),
      .i_rdata0 (w_al_rd0),
      .i_rdata1 (w_al_rd1),
      .o_split  (w_split),
      .o_wstrb0 (w_wstrb0),
      .o_wstrb1 (w_wstrb1),
      .o_wdata0 (w_wdata0),
      .o_wdata1 (w_wdata1),
      .o_ldata  (w_ldata)
   );

   assign w_last_ack = w_in_beat && bus.i_mem_ack && !((r_state == DPC_BEAT0) && w_split);
   assign w_end_txn  = w_last_ack || w_tmo;

`ifdef DRAM_TIMEOUT_EN
   localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic             r_err, w_new_beat;

   assign w_new_beat = (w_live && (bus.w_dram_le || bus.w_dram_we))
                    || ((r_state == DPC_BEAT0) && bus.i_mem_ack && w_split);
   assign w_cnt_nxt  = w_new_beat ? {CNT_W{1'b0}} : (r_cnt + CNT_W'(1));
   assign w_tmo      = w_in_beat && !bus.i_mem_ack && (r_cnt == CNT_LAST);

   // Per-beat wait counter and the sticky timeout flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= {CNT_W{1'b0}};
         r_err <= 1'b0;
      end else begin
         r_cnt <= w_cnt_nxt;
         r_err <= r_err | w_tmo;
      end
   end

   assign bus.o_err = r_err;
`else
   logic [31:0] w_unused_cfg;
   assign w_unused_cfg = 32'(TIMEOUT_CYCLES);
   assign w_tmo        = 1'b0;
   assign bus.o_err    = 1'b0;
`endif

   // Next state and next register values; everything holds unless a branch updates it.
   always_comb begin
      w_state_nxt     = r_state;
      w_off_nxt       = r_off;
      w_size_nxt      = r_size;
      w_zext_nxt      = r_zext;
      w_store_nxt     = r_store;
      w_wdata_nxt     = r_wdata;
      w_rdata0_nxt    = r_rdata0;
      w_req_nxt       = r_req;
      w_mem_we_nxt    = r_mem_we;
      w_mem_addr_nxt  = r_mem_addr;
      w_mem_wdata_nxt = r_mem_wdata;
      w_mem_wstrb_nxt = r_mem_wstrb;
      w_busy_nxt      = r_busy;
      w_odata_nxt     = r_odata;
      if (w_end_txn) begin
         w_req_nxt       = 1'b0;
         w_mem_we_nxt    = 1'b0;
         w_mem_wstrb_nxt = 4'b0000;
         w_mem_wdata_nxt = 32'd0;
         w_busy_nxt      = 1'b0;
         w_state_nxt     = DPC_DONE;
         if (r_store) begin
            w_odata_nxt = r_odata;
         end else if (w_tmo) begin
            w_odata_nxt = ERR_RDATA;
         end else begin
            w_odata_nxt = w_ldata;
         end
      end else begin
         case (r_state)
            DPC_IDLE: begin
               // A store strobe wins over a simultaneous load strobe.
               if (bus.w_dram_le || bus.w_dram_we) begin
                  w_off_nxt       = bus.w_dram_addr[1:0];
                  w_size_nxt      = bus.w_dram_ctrl[1:0];
                  w_zext_nxt      = bus.w_dram_ctrl[CTRL_ZEXT_BIT];
                  w_store_nxt     = bus.w_dram_we;
                  w_wdata_nxt     = bus.w_dram_wdata;
                  w_req_nxt       = 1'b1;
                  w_mem_we_nxt    = bus.w_dram_we;
                  w_mem_addr_nxt  = {bus.w_dram_addr[31:2], 2'b00};
                  w_mem_wstrb_nxt = bus.w_dram_we ? w_wstrb0 : 4'b0000;
                  w_mem_wdata_nxt = bus.w_dram_we ? w_wdata0 : 32'd0;
                  w_busy_nxt      = 1'b1;
                  w_state_nxt     = DPC_BEAT0;
               end else begin
                  w_state_nxt = DPC_IDLE;
               end
            end
            DPC_BEAT0: begin
               if (bus.i_mem_ack) begin
                  w_rdata0_nxt    = bus.i_mem_rdata;
                  w_mem_addr_nxt  = r_mem_addr + 32'd4;
                  w_mem_wstrb_nxt = r_store ? w_wstrb1 : 4'b0000;
                  w_mem_wdata_nxt = r_store ? w_wdata1 : 32'd0;
                  w_state_nxt     = DPC_BEAT1;
               end else begin
                  w_state_nxt = DPC_BEAT0;
               end
            end
            DPC_BEAT1: w_state_nxt = DPC_BEAT1;
            DPC_DONE:  w_state_nxt = DPC_IDLE;
            default:   w_state_nxt = DPC_IDLE;
         endcase
      end
   end

   // State, latched request and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= DPC_IDLE;
         r_off       <= 2'd0;
         r_size      <= 2'd0;
         r_zext      <= 1'b0;
         r_store     <= 1'b0;
         r_wdata     <= 32'd0;
         r_rdata0    <= 32'd0;
         r_req       <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= 32'd0;
         r_mem_wdata <= 32'd0;
         r_mem_wstrb <= 4'b0000;
         r_busy      <= 1'b0;
         r_odata     <= 32'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_off       <= w_off_nxt;
         r_size      <= w_size_nxt;
         r_zext      <= w_zext_nxt;
         r_store     <= w_store_nxt;
         r_wdata     <= w_wdata_nxt;
         r_rdata0    <= w_rdata0_nxt;
         r_req       <= w_req_nxt;
         r_mem_we    <= w_mem_we_nxt;
         r_mem_addr  <= w_mem_addr_nxt;
         r_mem_wdata <= w_mem_wdata_nxt;
         r_mem_wstrb <= w_mem_wstrb_nxt;
         r_busy      <= w_busy_nxt;
         r_odata     <= w_odata_nxt;
      end
   end

   assign bus.o_mem_req    = r_req;
   assign bus.o_mem_we     = r_mem_we;
   assign bus.o_mem_addr   = r_mem_addr;
   assign bus.o_mem_wdata  = r_mem_wdata;
   assign bus.o_mem_wstrb  = r_mem_wstrb;
   assign bus.w_dram_busy  = r_busy;
   assign bus.w_dram_odata = r_odata;

endmodule
